tff_divider_bank: RTL and testbench
===================================

// Module: tff_divider_bank
// PURPOSE
//  Bank of CHANNELS independent programmable divide-by-N toggle flip-flops for the horloge timebase.
//  Each channel counts enabled clock cycles and, at terminal count, emits a 1-cycle tick and flips
//  its toggle output, giving a 50% square wave at f_clock/(2*N). Divisors are reloadable at run time
//  without glitches. Feeds seconds/minutes/hours counters and display blink logic.
// PARAMETERS
//  CHANNELS  4   number of independent divider channels (>=1)
//  WIDTH     16  divisor/counter width in bits (>=2)
//  RST_DIV   0   divisor loaded into every channel at reset (0 = channel halted)
// PORTS
//  clock       in   1               single clock, all logic on rising edge
//  reset       in   1               synchronous, active-high; sampled on rising edge of clock
//  enable      in   1               global count enable; 0 freezes all counters, no ticks
//  sync_clear  in   1               zero all counters and toggle outputs; divisors kept
//  div_in      in   CHANNELS*WIDTH  divisor for channel i at bits [i*WIDTH +: WIDTH]
//  div_load    in   CHANNELS        per-channel strobe: capture div_in slice into shadow register
//  toggle_out  out  CHANNELS        per-channel toggle flip-flop output
//  tick        out  CHANNELS        per-channel 1-cycle pulse at terminal count (registered)
//  div_busy    out  CHANNELS        1 while a loaded divisor waits to become active
// BEHAVIOUR
//  Reset (sync): cnt=0, toggle_out=0, tick=0, div_busy=0, active=shadow=RST_DIV.
//  Per channel, state = {cnt, active, shadow, pending}; all outputs registered.
//  Count step (enable=1, active!=0): if cnt==active-1 -> cnt<=0, tick<=1, toggle_out<=~toggle_out,
//   and if pending -> active<=shadow, pending<=0; else cnt<=cnt+1, tick<=0.
//  Terminal count at cnt==active-1: N=1 toggles every enabled cycle, tick held high.
//  enable=0: cnt, toggle_out, active frozen; tick<=0; loads still captured.
//  active==0 (halted): cnt held 0, tick 0, toggle_out held; pending shadow becomes active on next
//   cycle regardless of enable (no terminal count to wait for).
//  div_load[i]=1: shadow<=slice, pending<=1, div_busy[i]<=1 next cycle. A load in the same cycle as a
//   terminal count is NOT applied at that terminal count; it applies at the next one.
//  Back-to-back loads: last value wins; only one switch-over happens.
//  div_busy[i] == pending; clears the cycle active takes the new value.
//  Priority: reset > sync_clear > count step. sync_clear: cnt<=0, toggle_out<=0, tick<=0; pending load
//   is applied immediately (active<=shadow) so the channel restarts aligned on the new divisor.
//  Reset mid-count discards pending loads. Counter arithmetic modulo 2^WIDTH, never exceeds active-1.
//  Latency: first tick WIDTH-independent, N enabled cycles after enable rises from cnt=0.
// CONFIGURATION
//  TFF_DIV_CASCADE_EN defined: channel i>0 advances only on cycles where tick[i-1] (pre-register
//   terminal-count strobe of channel i-1) is 1 and enable=1; channel 0 unchanged. Overall ratio of channel k
//   = product of N0..Nk. Halted upstream channel stalls all downstream channels.
//  Not defined: all channels count every enabled cycle independently.
// STRUCTURE
//  Shared package horloge_pkg: default WIDTH, RST_DIV constant, channel-slice index helper function.
//  One sub-module tff_div_channel (single counter + shadow + toggle), instantiated CHANNELS times in
//  a generate loop; top level only slices buses and routes cascade strobes.
// TESTING
//  T1 reset: reset=1 for 2 cycles, RST_DIV=0 -> all outputs 0, no ticks for 20 cycles with enable=1.
//  T2 divide: load N=3 on ch0, enable=1 -> tick every 3rd cycle, toggle_out period 6 cycles, 50% duty.
//  T3 reload: ch0 N=4 running; load N=2 mid-count (cnt=1) -> div_busy=1, old period completes,
//   then ticks every 2 cycles; div_busy drops at the switch cycle.
//  T4 edges: load coincident with terminal count -> applied one period later; N=1 -> toggle each cycle;
//   enable low 5 cycles mid-count -> cnt and toggle frozen, resume exactly.
//  T5 sync_clear with pending N=5 -> cnt=0, toggle_out=0, next tick after 5 cycles.
//  T6 TFF_DIV_CASCADE_EN: ch0 N=2, ch1 N=3 -> ch1 ticks every 6 cycles; without macro every 3.

Source files
------------

// File: rtl/horloge_pkg.sv
// Shared constants and helpers for the horloge timebase.
//
// Contents:
//   DEFAULT_CHANNELS  default number of divider channels in a bank
//   DEFAULT_WIDTH     default divisor/counter width in bits
//   RST_DIV_DEFAULT   divisor loaded at reset (0 = channel halted until loaded)
//   slice_lsb()       LSB position of channel ch inside a packed per-channel bus
package horloge_pkg;

  localparam int unsigned DEFAULT_CHANNELS = 4;
  localparam int unsigned DEFAULT_WIDTH    = 16;
  localparam int unsigned RST_DIV_DEFAULT  = 0;

  // Channel ch occupies bits [slice_lsb(ch, width) +: width] of a packed bus.
  function automatic int unsigned slice_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/tff_div_channel.sv
// One programmable divide-by-N toggle flip-flop channel.
//
// Counts cycles on which 'advance' is high. At terminal count (cnt == active-1)
// it emits a registered 1-cycle tick and flips toggle_out. A new divisor is
// captured into a shadow register and only swapped into 'active' at a terminal
// count, on sync_clear, or immediately while the channel is halted (active==0),
// so the output period never glitches.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high
//   sync_clear  in   zero counter and toggle; pending divisor applied at once
//   advance     in   count enable for this channel (global enable, maybe cascaded)
//   load        in   capture 'div' into the shadow register
//   div         in   WIDTH-bit divisor value
//   tc          out  combinational terminal-count strobe (feeds a cascade)
//   toggle_out  out  registered toggle flip-flop output
//   tick        out  registered 1-cycle pulse at terminal count
//   busy        out  a loaded divisor is waiting to become active
module tff_div_channel
  import horloge_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned RST_DIV = RST_DIV_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sync_clear,
  input  logic             advance,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  output logic             tc,
  output logic             toggle_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_DIV);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow;
  logic             pending;
  logic             halted;
  logic             swap_ok;

  assign halted = (active == '0);

  // A load arriving in the same cycle as a switch-over point is deferred to the
  // next one, so back-to-back loads produce a single switch to the last value.
  assign swap_ok = pending && !load;

  assign tc   = !reset && !sync_clear && !halted && advance &&
                (cnt == active - WIDTH'(1));
  assign busy = pending;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below reads the pre-edge values of cnt/active/pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      toggle_out <= 1'b0;
      tick       <= 1'b0;
      pending    <= 1'b0;
      active     <= RST_VAL;
      shadow     <= RST_VAL;
    end else begin
      if (sync_clear) begin
        cnt        <= '0;
        toggle_out <= 1'b0;
        tick       <= 1'b0;
        if (swap_ok) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end else if (halted) begin
        // No terminal count exists while halted, so a pending divisor is taken
        // on the next cycle whether or not the channel is enabled.
        cnt  <= '0;
        tick <= 1'b0;
        if (swap_ok) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end else if (advance) begin
        if (tc) begin
          cnt        <= '0;
          tick       <= 1'b1;
          toggle_out <= ~toggle_out;
          if (swap_ok) begin
            active  <= shadow;
            pending <= 1'b0;
          end
        end else begin
          cnt  <= cnt + WIDTH'(1);
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end

      // Loads are captured in every non-reset cycle; placed last so a new
      // load re-arms pending even if a swap happened above.
      if (load) begin
        shadow  <= div;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tff_divider_bank.sv
// Bank of CHANNELS independent programmable divide-by-N toggle flip-flops.
//
// Each channel produces a 50% square wave at f_clock/(2*N) plus a 1-cycle tick
// every N enabled cycles. This level only slices the divisor bus and routes the
// per-channel count enables.
//
// Configuration macro:
//   TFF_DIV_CASCADE_EN  when defined, channel i>0 advances only on cycles where
//                       channel i-1 reaches terminal count (and enable=1), so
//                       channel k divides by N0*N1*...*Nk. When undefined,
//                       every channel counts every enabled cycle.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high
//   enable      in   global count enable
//   sync_clear  in   zero all counters and toggles; divisors kept
//   div_in      in   CHANNELS*WIDTH divisors, channel i at [i*WIDTH +: WIDTH]
//   div_load    in   per-channel divisor capture strobe
//   toggle_out  out  per-channel toggle output
//   tick        out  per-channel 1-cycle terminal-count pulse
//   div_busy    out  per-channel pending-divisor flag
module tff_divider_bank
  import horloge_pkg::*;
#(
  parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned RST_DIV  = RST_DIV_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      sync_clear,
  input  logic [CHANNELS*WIDTH-1:0] div_in,
  input  logic [CHANNELS-1:0]       div_load,
  output logic [CHANNELS-1:0]       toggle_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       div_busy
);

  // Terminal-count strobes that no downstream channel consumes; collected here
  // so they stay visible for debug.
  logic [CHANNELS-1:0] tc_unused;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic advance;
    logic tc;

`ifdef TFF_DIV_CASCADE_EN
    if (i == 0) begin : g_head
      assign advance = enable;
    end else begin : g_link
      // Per-block scalars keep the cascade chain free of a self-looping vector.
      assign advance = enable && g_ch[i-1].tc;
    end
`else
    assign advance = enable;
`endif

    assign tc_unused[i] = tc;

    tff_div_channel #(
      .WIDTH   (WIDTH),
      .RST_DIV (RST_DIV)
    ) u_channel (
      .clock      (clock),
      .reset      (reset),
      .sync_clear (sync_clear),
      .advance    (advance),
      .load       (div_load[i]),
      .div        (div_in[slice_lsb(i, WIDTH) +: WIDTH]),
      .tc         (tc),
      .toggle_out (toggle_out[i]),
      .tick       (tick[i]),
      .busy       (div_busy[i])
    );
  end

endmodule

// File: tb/tb_tff_divider_bank.sv
// Directed self-checking bench for tff_divider_bank (4 channels, 16-bit).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_tff_divider_bank;

  localparam int CH = 4;
  localparam int W  = 16;

`ifdef TFF_DIV_CASCADE_EN
  localparam int CH1_PERIOD = 6;
`else
  localparam int CH1_PERIOD = 3;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic            sync_clear;
  logic [CH*W-1:0] div_in;
  logic [CH-1:0]   div_load;
  logic [CH-1:0]   toggle_out;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   div_busy;

  int checks = 0;
  int errors = 0;

  tff_divider_bank #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .RST_DIV  (0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .sync_clear (sync_clear),
    .div_in     (div_in),
    .div_load   (div_load),
    .toggle_out (toggle_out),
    .tick       (tick),
    .div_busy   (div_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: time limit reached before summary");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_div(input int ch, input logic [W-1:0] val);
    div_in[ch*W +: W] = val;
  endtask

  initial begin
    logic [CH-1:0] seen;

    reset      = 1'b1;
    enable     = 1'b0;
    sync_clear = 1'b0;
    div_in     = '0;
    div_load   = '0;

    // T1: reset, then no activity while every channel is halted
    step(2);
    check("t1_reset_toggle", toggle_out, 0);
    check("t1_reset_tick", tick, 0);
    check("t1_reset_busy", div_busy, 0);
    reset  = 1'b0;
    enable = 1'b1;
    seen   = '0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      seen = seen | tick | toggle_out | div_busy;
    end
    check("t1_halted_quiet", seen, 0);

    // T2: N=3 on channel 0
    set_div(0, 16'd3);
    div_load = 4'b0001;
    step(1);
    check("t2_busy_set", div_busy[0], 1);
    div_load = '0;
    step(1);
    check("t2_busy_clear", div_busy[0], 0);
    check("t2_tick_idle", tick[0], 0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("t2_tick", tick[0], (k % 3 == 0));
      check("t2_toggle", toggle_out[0], (k / 3) % 2);
    end

    // T3: realign on N=4, then reload N=2 while cnt=1
    set_div(0, 16'd4);
    div_load = 4'b0001;
    step(1);
    div_load   = '0;
    sync_clear = 1'b1;
    step(1);
    sync_clear = 1'b0;
    check("t3_clr_toggle", toggle_out[0], 0);
    check("t3_clr_busy", div_busy[0], 0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("t3_n4_tick", tick[0], (k == 4));
    end
    step(1);
    set_div(0, 16'd2);
    div_load = 4'b0001;
    step(1);
    div_load = '0;
    check("t3_busy_mid", div_busy[0], 1);
    check("t3_tick_mid", tick[0], 0);
    step(1);
    check("t3_busy_hold", div_busy[0], 1);
    check("t3_tick_hold", tick[0], 0);
    step(1);
    check("t3_old_tc_tick", tick[0], 1);
    check("t3_busy_drop", div_busy[0], 0);
    check("t3_old_tc_toggle", toggle_out[0], 0);
    for (int k = 9; k <= 12; k++) begin
      step(1);
      check("t3_n2_tick", tick[0], (k % 2 == 0));
    end
    check("t3_n2_toggle", toggle_out[0], 0);

    // T4a: load coincident with a terminal count waits one period
    step(1);
    check("t4a_pre_tick", tick[0], 0);
    set_div(0, 16'd3);
    div_load = 4'b0001;
    step(1);
    div_load = '0;
    check("t4a_tc_tick", tick[0], 1);
    check("t4a_tc_busy", div_busy[0], 1);
    check("t4a_tc_toggle", toggle_out[0], 1);
    step(1);
    check("t4a_old_cnt_tick", tick[0], 0);
    step(1);
    check("t4a_old_period_tick", tick[0], 1);
    check("t4a_switch_busy", div_busy[0], 0);
    step(1);
    check("t4a_n3_tick_a", tick[0], 0);
    step(1);
    check("t4a_n3_tick_b", tick[0], 0);
    step(1);
    check("t4a_n3_tick_c", tick[0], 1);

    // T4c: enable low for 5 cycles mid-count freezes the channel
    sync_clear = 1'b1;
    step(1);
    sync_clear = 1'b0;
    step(1);
    check("t4c_cnt1_tick", tick[0], 0);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("t4c_frozen_tick", tick[0], 0);
      check("t4c_frozen_toggle", toggle_out[0], 0);
    end
    enable = 1'b1;
    step(1);
    check("t4c_resume_tick", tick[0], 0);
    step(1);
    check("t4c_resume_tc", tick[0], 1);
    check("t4c_resume_toggle", toggle_out[0], 1);

    // T4b: N=1 toggles every enabled cycle with tick held high
    set_div(0, 16'd1);
    div_load = 4'b0001;
    step(1);
    div_load = '0;
    check("t4b_busy", div_busy[0], 1);
    step(1);
    check("t4b_wait_tick", tick[0], 0);
    step(1);
    check("t4b_switch_tick", tick[0], 1);
    check("t4b_switch_busy", div_busy[0], 0);
    check("t4b_switch_toggle", toggle_out[0], 0);
    step(1);
    check("t4b_n1_tick_a", tick[0], 1);
    check("t4b_n1_toggle_a", toggle_out[0], 1);
    step(1);
    check("t4b_n1_tick_b", tick[0], 1);
    check("t4b_n1_toggle_b", toggle_out[0], 0);

    // T5: sync_clear with N=5 pending applies it at once
    set_div(0, 16'd5);
    div_load = 4'b0001;
    step(1);
    div_load = '0;
    check("t5_busy_pending", div_busy[0], 1);
    sync_clear = 1'b1;
    step(1);
    sync_clear = 1'b0;
    check("t5_clr_toggle", toggle_out[0], 0);
    check("t5_clr_tick", tick[0], 0);
    check("t5_clr_busy", div_busy[0], 0);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check("t5_n5_tick", tick[0], (k == 5));
    end
    check("t5_n5_toggle", toggle_out[0], 1);

    // T6: ch0 N=2, ch1 N=3 (cascade gives ch1 a 6-cycle period)
    set_div(0, 16'd2);
    set_div(1, 16'd3);
    div_load = 4'b0011;
    step(1);
    div_load   = '0;
    sync_clear = 1'b1;
    step(1);
    sync_clear = 1'b0;
    check("t6_busy_clear", div_busy[1:0], 0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("t6_ch0_tick", tick[0], (k % 2 == 0));
      check("t6_ch1_tick", tick[1], (k % CH1_PERIOD == 0));
    end

    // T7: reset discards a pending load
    set_div(0, 16'd9);
    div_load = 4'b0001;
    step(1);
    div_load = '0;
    check("t7_busy_before", div_busy[0], 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t7_reset_busy", div_busy, 0);
    check("t7_reset_toggle", toggle_out, 0);
    check("t7_reset_tick", tick, 0);
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      seen = seen | tick | toggle_out | div_busy;
    end
    check("t7_after_reset_quiet", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
